dmem_arbiter: RTL

//  Shares the single-port data memory between two requesters: the CPU load/store path (cpu_*) and the debug/loader port (dbg_*).
//  - Fixed priority to CPU, with a starvation guard that forces a debug grant.
//  - Rejects misaligned accesses before they reach memory.
//  - Returns registered read data with a one-cycle response.
//  - Sits between the MEM stage and the data memory; drives the memory's MemWr/MemRead/addr/write_data/funct3 pins.

---
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU load/store
// path and the debug/loader port. CPU has fixed priority, and a starvation
// counter forces a debug grant after STARVE_LIMIT consecutive denied cycles.
// Misaligned accesses are granted and acknowledged with err, but never reach
// the memory. Each grant is answered one cycle later with a registered response.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        n_rst,

    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [11:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    input  logic [2:0]  cpu_funct3_i,
    output logic        cpu_gnt_o,
    output logic        cpu_rvalid_o,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_err_o,

    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [11:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    input  logic [2:0]  dbg_funct3_i,
    output logic        dbg_gnt_o,
    output logic        dbg_rvalid_o,
    output logic [31:0] dbg_rdata_o,
    output logic        dbg_err_o,

    output logic        mem_wr_o,
    output logic        mem_rd_o,
    output logic [11:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [2:0]  mem_funct3_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    owner_e           resp_owner_q;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             force_dbg, cpu_gnt, dbg_gnt, any_gnt;
    logic             sel_we, misaligned, access_ok;
    logic [11:0]      sel_addr;
    logic [31:0]      sel_wdata, resp_rdata;
    logic [2:0]       sel_funct3;
    logic             cpu_err_q, dbg_err_q;
    logic [31:0]      cpu_rdata_q, dbg_rdata_q;

    assign force_dbg = (starve_cnt_q >= CNT_W'(STARVE_LIMIT));
    assign dbg_gnt   = dbg_req_i & (force_dbg | ~cpu_req_i);
    assign cpu_gnt   = cpu_req_i & ~dbg_gnt;
    assign any_gnt   = cpu_gnt | dbg_gnt;

    // Route the granted requester onto the memory side; idle bus is all zero.
    always_comb begin
        sel_we     = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_funct3 = '0;
        if (cpu_gnt) begin
            sel_we     = cpu_we_i;
            sel_addr   = cpu_addr_i;
            sel_wdata  = cpu_wdata_i;
            sel_funct3 = cpu_funct3_i;
        end else if (dbg_gnt) begin
            sel_we     = dbg_we_i;
            sel_addr   = dbg_addr_i;
            sel_wdata  = dbg_wdata_i;
            sel_funct3 = dbg_funct3_i;
        end
    end

    // Halfword accesses need an even address, word accesses a multiple of four.
    always_comb begin
        case (sel_funct3[1:0])
            2'b01:   misaligned = sel_addr[0];
            2'b10:   misaligned = |sel_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign access_ok    = any_gnt & ~misaligned;
    assign mem_wr_o     = access_ok & sel_we;
    assign mem_rd_o     = access_ok & ~sel_we;
    assign mem_addr_o   = sel_addr;
    assign mem_wdata_o  = sel_wdata;
    assign mem_funct3_o = sel_funct3;

    // Stores and rejected accesses answer with zero data.
    assign resp_rdata = mem_rd_o ? mem_rdata_i : '0;

    // Count consecutive cycles in which debug asks but is refused; saturate.
    always_comb begin
        if (dbg_gnt | ~dbg_req_i) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q < CNT_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Response FSM: remember who was granted and capture its response.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            resp_owner_q <= OWN_NONE;
            cpu_err_q    <= 1'b0;
            dbg_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else if (cpu_gnt) begin
            resp_owner_q <= OWN_CPU;
            cpu_rdata_q  <= resp_rdata;
            cpu_err_q    <= misaligned;
            dbg_err_q    <= 1'b0;
        end else if (dbg_gnt) begin
            resp_owner_q <= OWN_DBG;
            dbg_rdata_q  <= resp_rdata;
            dbg_err_q    <= misaligned;
            cpu_err_q    <= 1'b0;
        end else begin
            resp_owner_q <= OWN_NONE;
            cpu_err_q    <= 1'b0;
            dbg_err_q    <= 1'b0;
        end
    end

    assign cpu_gnt_o    = cpu_gnt;
    assign dbg_gnt_o    = dbg_gnt;
    assign cpu_rvalid_o = (resp_owner_q == OWN_CPU);
    assign dbg_rvalid_o = (resp_owner_q == OWN_DBG);
    assign cpu_rdata_o  = cpu_rdata_q;
    assign dbg_rdata_o  = dbg_rdata_q;
    assign cpu_err_o    = cpu_err_q;
    assign dbg_err_o    = dbg_err_q;

endmodule
